// File: rtl/piece_move_scheduler_if.sv
// Command handshake between the move scheduler and the falling-piece datapath.
// The scheduler offers one command at a time; the datapath reports completion and whether the move was blocked.
interface piece_move_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_o;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_blocked;

  modport master (
    output cmd_valid,
    output cmd_o,
    input  cmd_ready,
    input  cmd_done,
    input  cmd_blocked
  );

  modport slave (
    input  cmd_valid,
    input  cmd_o,
    output cmd_ready,
    output cmd_done,
    output cmd_blocked
  );
endinterface

// File: rtl/piece_move_scheduler.sv
// Motion scheduler for the falling tetromino: gravity tick, button edge capture,
// arbitration and a single-outstanding command handshake with lock request.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no command outstanding, arbitrate pending requests
//   S_ISSUE | cmd_valid high, cmd_o held until cmd_ready
//   S_WAIT  | command accepted, waiting for cmd_done
//   S_LOCK  | lock_o pulse, all pending work and gravity cleared
module piece_move_scheduler #(
  parameter int GRAV_INIT       = 50,
  parameter int GRAV_STEP       = 5,
  parameter int GRAV_MIN        = 5,
  parameter int SOFT_PERIOD     = 3,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   left_i,
  input  logic                   right_i,
  input  logic                   rot_i,
  input  logic                   hdrop_i,
  input  logic                   soft_i,
  input  logic                   lines_valid,
  input  logic [2:0]             lines_cnt,
  piece_move_scheduler_if.master cmd,
  output logic                   lock_o,
  output logic [3:0]             level_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_ROT   = 3'd4;
  localparam logic [2:0] CMD_HDROP = 3'd5;

  // pend vector layout: gravity in bit 0, buttons above it in btn_now order
  localparam int P_DOWN  = 0;
  localparam int P_LEFT  = 1;
  localparam int P_RIGHT = 2;
  localparam int P_ROT   = 3;
  localparam int P_HDROP = 4;

  localparam logic [11:0] INIT12 = 12'(GRAV_INIT);
  localparam logic [11:0] STEP12 = 12'(GRAV_STEP);
  localparam logic [11:0] MIN12  = 12'(GRAV_MIN);

  state_t      state, state_nx;
  logic [2:0]  cmd_q, cmd_nx;
  logic        valid_q, valid_nx;
  logic        lock_q, lock_nx;

  logic [3:0]  btn_now, btn_q, btn_rise;
  logic [4:0]  pend_q, pend_set, pend_clr, avail;
  logic        clr_all;
  logic        pick;

  logic [7:0]  grav_cnt;
  logic [7:0]  period;
  logic [11:0] grav_drop;
  logic        grav_fire;

  logic [7:0]  line_total, total_nx, level_raw;
  logic [8:0]  line_sum;
  logic [3:0]  level_q, level_nx;

  assign btn_now  = {hdrop_i, rot_i, right_i, left_i};
  assign btn_rise = btn_now & ~btn_q;

  assign grav_drop = 12'(level_q) * STEP12;

  always_comb begin
    if (soft_i)
      period = 8'(SOFT_PERIOD);
    else if (grav_drop + MIN12 >= INIT12)
      period = 8'(GRAV_MIN);
    else
      period = 8'(INIT12 - grav_drop);
  end

  // >= rather than == so a shortened period fires at once instead of running to 255
  assign grav_fire = en && (grav_cnt >= (period - 8'd1));
  assign pend_set  = {btn_rise & {4{en}}, grav_fire};

  always_comb begin
    line_sum  = {1'b0, line_total} + 9'(lines_cnt);
    total_nx  = line_total;
    if (lines_valid)
      total_nx = line_sum[8] ? 8'hFF : line_sum[7:0];
    level_raw = total_nx / 8'(LINES_PER_LEVEL);
    level_nx  = (level_raw > 8'd9) ? 4'd9 : level_raw[3:0];
  end

  always_comb begin
    state_nx = state;
    cmd_nx   = cmd_q;
    valid_nx = 1'b0;
    lock_nx  = 1'b0;
    pend_clr = '0;
    clr_all  = 1'b0;
    avail    = pend_q;
    pick     = 1'b0;

    case (state)
      S_IDLE: begin
        if (en) begin
          if (pend_q[P_LEFT] && pend_q[P_RIGHT]) begin
            pend_clr[P_LEFT]  = 1'b1;
            pend_clr[P_RIGHT] = 1'b1;
            avail[P_LEFT]     = 1'b0;
            avail[P_RIGHT]    = 1'b0;
          end
          pick = 1'b1;
          if (avail[P_HDROP]) begin
            cmd_nx = CMD_HDROP;
            pend_clr[P_HDROP] = 1'b1;
          end else if (avail[P_ROT]) begin
            cmd_nx = CMD_ROT;
            pend_clr[P_ROT] = 1'b1;
          end else if (avail[P_LEFT]) begin
            cmd_nx = CMD_LEFT;
            pend_clr[P_LEFT] = 1'b1;
          end else if (avail[P_RIGHT]) begin
            cmd_nx = CMD_RIGHT;
            pend_clr[P_RIGHT] = 1'b1;
          end else if (avail[P_DOWN]) begin
            cmd_nx = CMD_DOWN;
            pend_clr[P_DOWN] = 1'b1;
          end else begin
            pick = 1'b0;
          end
          if (pick) begin
            state_nx = S_ISSUE;
            valid_nx = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        valid_nx = 1'b1;
        if (cmd.cmd_ready) begin
          state_nx = S_WAIT;
          valid_nx = 1'b0;
        end
      end
      S_WAIT: begin
        if (cmd.cmd_done) begin
          if ((cmd_q == CMD_HDROP) || ((cmd_q == CMD_DOWN) && cmd.cmd_blocked)) begin
            state_nx = S_LOCK;
            lock_nx  = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        clr_all  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // leaving the falling phase abandons any outstanding command
    if (!en) begin
      state_nx = S_IDLE;
      valid_nx = 1'b0;
      lock_nx  = 1'b0;
      clr_all  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cmd_q   <= CMD_NONE;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cmd_q   <= cmd_nx;
      valid_q <= valid_nx;
      lock_q  <= lock_nx;
    end
  end

  // a rise landing on the same edge as its own issue survives: set beats clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q  <= '0;
      pend_q <= '0;
    end else begin
      btn_q <= btn_now;
      if (clr_all)
        pend_q <= '0;
      else
        pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      grav_cnt <= '0;
    else if (clr_all)
      grav_cnt <= '0;
    else if (grav_fire)
      grav_cnt <= '0;
    else
      grav_cnt <= grav_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_total <= '0;
      level_q    <= '0;
    end else begin
      line_total <= total_nx;
      level_q    <= level_nx;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_o     = cmd_q;
  assign lock_o        = lock_q;
  assign level_o       = level_q;

endmodule

// File: doc/piece_move_scheduler.md
# piece_move_scheduler

Sequences every motion of the active falling tetromino. It generates the level-scaled gravity tick, edge-detects player move requests and arbitrates them with gravity. It issues exactly one command at a time to the falling-piece datapath over a valid/ready/done handshake, and pulses a lock request when a piece can no longer fall. It sits between the input synchronisers and the game FSM's movement datapath, replacing ad-hoc per-state sampling of gravity and button strobes.

## Interface
- GRAV_INIT, 50: gravity period in clk cycles at level 0 (2..255)
- GRAV_STEP, 5: period reduction per level
- GRAV_MIN, 5: period floor (≥2)
- SOFT_PERIOD, 3: gravity period while soft drop is held (≥2)
- LINES_PER_LEVEL, 10: cleared lines per level increment
- clk  in  1  game clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  piece active (FSM in falling phase); low = scheduler idle
- left_i, right_i, rot_i, hdrop_i  in  1 each  synchronised level inputs, acted on rising edge
- soft_i  in  1  soft drop held (level)
- lines_valid  in  1  one-cycle pulse, lines_cnt valid
- lines_cnt  in  3  lines cleared by last lock (0..4)
- cmd_ready  in  1  datapath accepts cmd
- cmd_done  in  1  datapath finished the accepted cmd (one-cycle pulse)
- cmd_blocked  in  1  qualified by cmd_done: move was not applied
- cmd_valid  out  1  command offered
- cmd_o  out  3  0 NONE, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROT, 5 HDROP
- lock_o  out  1  one-cycle lock request to FSM
- level_o  out  4  current level (0..9)

## Operation
- States: IDLE, ISSUE, WAIT, LOCK.
- Edge detect: one registered copy per button. A rise while en=1 sets that pend bit; repeats while pending coalesce. Pend bits are kept while ISSUE/WAIT.
- Gravity: 8-bit counter increments while en. When it reaches period−1, it sets grav_pend and wraps to 0. period = SOFT_PERIOD if soft_i, else max(GRAV_INIT − level·GRAV_STEP, GRAV_MIN).
- IDLE: if en and any pend, go to ISSUE with cmd_o chosen by priority: HDROP > ROT > LEFT/RIGHT > DOWN.
  - LEFT and RIGHT pending together: both cleared, neither issued; arbitration proceeds on the remaining bits in the same cycle.
  - The chosen pend bit clears on entry to ISSUE.
- ISSUE: cmd_valid=1, cmd_o held stable until cmd_ready is sampled high, then go to WAIT with cmd_valid=0.
- WAIT: on cmd_done:
  - DOWN with cmd_blocked, or any HDROP: go to LOCK.
  - Otherwise go to IDLE. A blocked LEFT/RIGHT/ROT is dropped silently.
- LOCK: lock_o=1 for one cycle. Clear all pend bits and the gravity counter, then go to IDLE.
- Level: an 8-bit saturating line total adds lines_cnt on lines_valid (accepted in any state, including en=0). level = min(total / LINES_PER_LEVEL, 9).
- en low, any state: next state IDLE, cmd_valid=0, pend bits and gravity counter cleared, level retained. A command already accepted is abandoned; its late cmd_done is ignored.

## Timing
- Reset: state IDLE, cmd_valid 0, cmd_o 0, lock_o 0, level_o 0, all counters and pend bits 0, button history 0.
- All outputs are registered.
- Input rise sampled at edge k sets pend at k; cmd_valid is visible after edge k+1 (2-cycle latency) when idle.
- Handshake: a transfer occurs on the edge where cmd_valid & cmd_ready. cmd_done may arrive no earlier than the cycle after the transfer.
- lock_o is asserted the cycle after the blocking cmd_done.
- Gravity: the first grav_pend occurs period cycles after en rises.
- A change of period (level or soft_i) takes effect immediately. If counter ≥ new period−1, it fires and wraps on the next edge.
- Simultaneous events:
  - A button rise and its own issue: the rise is re-latched.
  - Gravity wrap during LOCK: discarded.
  - reset_n low mid-transaction: immediate return to reset values.

## Test plan
- Gravity at level 0: en=1, no buttons, cmd_ready tied 1, cmd_done returned 1 cycle after each transfer → DOWN issued every 50 cycles. soft_i=1 → every 3 cycles.
- Priority: left_i, rot_i and hdrop_i rise on the same cycle → HDROP issued first, then lock_o; ROT and LEFT are cleared by the lock and never issued.
- Cancel: left_i and right_i rise together with grav_pend set → neither LEFT nor RIGHT; DOWN is issued.
- Backpressure: cmd_ready low for 7 cycles → cmd_valid=1 and cmd_o=2 stable throughout, transfer on the 8th cycle, one command only.
- Lock: DOWN done with cmd_blocked=1 → lock_o high exactly 1 cycle, next cmd only after a fresh pend.
- Level: lines_valid ×3 with lines_cnt=4 → level_o=1, DOWN period 45. A further 90 lines → level_o saturates at 9, period 5.
- Abort: en falls while in WAIT → cmd_valid=0, state IDLE; a subsequent cmd_done produces no lock_o.
